// File: rtl/rev_pe_run_sched.sv
// Run scheduler for the reversible MAC PE: issues one batch of input-buffer reads, tracks items
// through the fixed-latency pipe, drives output-buffer writes, tallies reverse-check errors, arbitrates host readout.
// Latency: rd_en_o one cycle after start_i, writes PIPE_LAT cycles after reads. No backpressure; host waits for IDLE.
module rev_pe_run_sched #(
    parameter int DATA_NUM = 16,
    parameter int ADDR_W   = $clog2(DATA_NUM),
    parameter int PIPE_LAT = 3,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              stage_en_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    input  logic              err1_i,
    input  logic              err2_i,
    output logic [ERR_W-1:0]  err1_cnt_o,
    output logic [ERR_W-1:0]  err2_cnt_o,
    output logic              first_err_vld_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    input  logic              host_rd_req_i,
    output logic              host_rd_gnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_NUM - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_t              state;
    logic [PIPE_LAT-1:0] pipe_vld;
    logic [ADDR_W-1:0]   pipe_addr [PIPE_LAT];

    logic run_start;
    logic run_abort;
    logic e1_hit;
    logic e2_hit;

    assign run_start = (state == IDLE) && start_i && !abort_i;
    assign run_abort = (state != IDLE) && abort_i;

    // Errors only count against a live item in the slot they refer to.
    assign e1_hit = err1_i && pipe_vld[1];
    assign e2_hit = err2_i && pipe_vld[2];

    assign wr_en_o       = pipe_vld[PIPE_LAT-1];
    assign wr_addr_o     = pipe_addr[PIPE_LAT-1];
    assign busy_o        = (state != IDLE);
    assign stage_en_o    = (state == ISSUE) || (state == DRAIN);
    assign done_o        = (state == DONE);
    assign host_rd_gnt_o = host_rd_req_i && (state == IDLE) && !start_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
            aborted_o <= 1'b0;
        end else if (run_abort) begin
            state     <= IDLE;
            rd_en_o   <= 1'b0;
            aborted_o <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (run_start) begin
                        state     <= ISSUE;
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= '0;
                        aborted_o <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (rd_addr_o == LAST_ADDR) begin
                        state   <= DRAIN;
                        rd_en_o <= 1'b0;
                    end else begin
                        rd_addr_o <= rd_addr_o + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (wr_en_o && (wr_addr_o == LAST_ADDR))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid/address pipe mirrors the datapath registers; flushed on start and abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < PIPE_LAT; i++)
                pipe_addr[i] <= '0;
        end else if (run_start || run_abort) begin
            pipe_vld <= '0;
            for (int i = 0; i < PIPE_LAT; i++)
                pipe_addr[i] <= '0;
        end else begin
            pipe_vld     <= {pipe_vld[PIPE_LAT-2:0], rd_en_o};
            pipe_addr[0] <= rd_addr_o;
            for (int i = 1; i < PIPE_LAT; i++)
                pipe_addr[i] <= pipe_addr[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err1_cnt_o       <= '0;
            err2_cnt_o       <= '0;
            first_err_vld_o  <= 1'b0;
            first_err_addr_o <= '0;
        end else if (run_start) begin
            err1_cnt_o       <= '0;
            err2_cnt_o       <= '0;
            first_err_vld_o  <= 1'b0;
            first_err_addr_o <= '0;
        end else begin
            if (e1_hit && (err1_cnt_o != ERR_MAX))
                err1_cnt_o <= err1_cnt_o + ERR_W'(1);
            if (e2_hit && (err2_cnt_o != ERR_MAX))
                err2_cnt_o <= err2_cnt_o + ERR_W'(1);
            // Slot 2 holds the older item, so it wins a same-cycle tie.
            if (!first_err_vld_o && (e1_hit || e2_hit)) begin
                first_err_vld_o  <= 1'b1;
                first_err_addr_o <= e2_hit ? pipe_addr[2] : pipe_addr[1];
            end
        end
    end

endmodule

// File: tb/tb_rev_pe_run_sched.sv
// Bench for rev_pe_run_sched: directed batches, expected reads/writes/done pushed to queues at stimulus time,
// a negedge monitor pops and compares whenever the DUT presents a read, write or done.
module tb_rev_pe_run_sched;

    logic       clk;
    logic       rst_n;
    logic       start_i, abort_i, err1_i, err2_i, host_rd_req_i;
    logic       rd_en_o, stage_en_o, wr_en_o, first_err_vld_o;
    logic [3:0] rd_addr_o, wr_addr_o, first_err_addr_o;
    logic [7:0] err1_cnt_o, err2_cnt_o;
    logic       host_rd_gnt_o, busy_o, done_o, aborted_o;

    // Second instance with a long batch so an error counter can saturate.
    logic       start2, err1_2;
    logic       rd_en2, stage_en2, wr_en2, fev2, gnt2, busy2, done2, aborted2;
    logic [8:0] rd_addr2, wr_addr2, fea2;
    logic [7:0] e1cnt2, e2cnt2;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {int cyc; int addr;} ev_t;
    typedef struct {int cyc; int e1; int e2; int fev; int fea;} dn_t;
    ev_t exp_rd[$];
    ev_t exp_wr[$];
    dn_t exp_dn[$];

    rev_pe_run_sched dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .stage_en_o(stage_en_o),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .err1_i(err1_i), .err2_i(err2_i),
        .err1_cnt_o(err1_cnt_o), .err2_cnt_o(err2_cnt_o),
        .first_err_vld_o(first_err_vld_o), .first_err_addr_o(first_err_addr_o),
        .host_rd_req_i(host_rd_req_i), .host_rd_gnt_o(host_rd_gnt_o),
        .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
    );

    rev_pe_run_sched #(.DATA_NUM(512)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .abort_i(1'b0),
        .rd_en_o(rd_en2), .rd_addr_o(rd_addr2), .stage_en_o(stage_en2),
        .wr_en_o(wr_en2), .wr_addr_o(wr_addr2), .err1_i(err1_2), .err2_i(1'b0),
        .err1_cnt_o(e1cnt2), .err2_cnt_o(e2cnt2),
        .first_err_vld_o(fev2), .first_err_addr_o(fea2),
        .host_rd_req_i(1'b0), .host_rd_gnt_o(gnt2),
        .busy_o(busy2), .done_o(done2), .aborted_o(aborted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected DUT output at cycle %0d", name, cyc);
    endtask

    // Monitor: pops an expectation every time the DUT presents an event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en_o) begin
                if (exp_rd.size() == 0) unexpected("rd_extra");
                else begin
                    ev_t e;
                    e = exp_rd.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_addr", int'(rd_addr_o), e.addr);
                end
            end
            if (wr_en_o) begin
                if (exp_wr.size() == 0) unexpected("wr_extra");
                else begin
                    ev_t e;
                    e = exp_wr.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", int'(wr_addr_o), e.addr);
                end
            end
            if (done_o) begin
                if (exp_dn.size() == 0) unexpected("done_extra");
                else begin
                    dn_t d;
                    d = exp_dn.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("err1_cnt", int'(err1_cnt_o), d.e1);
                    chk("err2_cnt", int'(err2_cnt_o), d.e2);
                    chk("first_err_vld", int'(first_err_vld_o), d.fev);
                    chk("first_err_addr", int'(first_err_addr_o), d.fea);
                    chk("aborted_at_done", int'(aborted_o), 0);
                end
            end
        end
    end

    // One batch: start at cycle 0, error masks indexed by cycle, optional abort cycle.
    task automatic run_batch(input logic [31:0] m1, input logic [31:0] m2, input int abort_at,
                             input int e1, input int e2, input int fev, input int fea);
        int t0;
        int lim;
        @(posedge clk); #1;
        start_i = 1'b1;
        t0 = cyc;
        lim = (abort_at < 0) ? 1000 : abort_at;
        for (int i = 0; i < 16; i++) begin
            if (1 + i <= lim) exp_rd.push_back('{t0 + 1 + i, i});
            if (4 + i <= lim) exp_wr.push_back('{t0 + 4 + i, i});
        end
        if (abort_at < 0) exp_dn.push_back('{t0 + 20, e1, e2, fev, fea});
        #1 chk("gnt_on_start", int'(host_rd_gnt_o), 0);
        for (int k = 1; k < 24; k++) begin
            @(posedge clk); #1;
            start_i = (k == 6);
            abort_i = (k == abort_at);
            err1_i  = m1[k];
            err2_i  = m2[k];
            if (k == 5) begin
                #1;
                chk("busy_mid", int'(busy_o), 1);
                chk("stage_en_mid", int'(stage_en_o), 1);
                chk("gnt_busy", int'(host_rd_gnt_o), 0);
            end
        end
        @(posedge clk); #1;
        start_i = 1'b0; abort_i = 1'b0; err1_i = 1'b0; err2_i = 1'b0;
        chk("busy_after", int'(busy_o), 0);
        chk("aborted_after", int'(aborted_o), (abort_at >= 0) ? 1 : 0);
        chk("gnt_idle", int'(host_rd_gnt_o), int'(host_rd_req_i));
    endtask

    initial begin
        int t0;
        rst_n = 1'b0;
        start_i = 1'b0; abort_i = 1'b0; err1_i = 1'b0; err2_i = 1'b0;
        host_rd_req_i = 1'b0; start2 = 1'b0; err1_2 = 1'b0;
        #1;
        chk("rst_rd_en", int'(rd_en_o), 0);
        chk("rst_wr_en", int'(wr_en_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err1", int'(err1_cnt_o), 0);
        chk("rst_fev", int'(first_err_vld_o), 0);
        chk("rst_aborted", int'(aborted_o), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Host readout in IDLE, then held during a clean batch.
        host_rd_req_i = 1'b1;
        #1 chk("gnt_idle_req", int'(host_rd_gnt_o), 1);
        run_batch(32'h0, 32'h0, -1, 0, 0, 0, 0);
        host_rd_req_i = 1'b0;

        // start and abort together in IDLE: stays idle, nothing issued.
        @(posedge clk); #1; start_i = 1'b1; abort_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0; abort_i = 1'b0;
        chk("start_abort_idle_busy", int'(busy_o), 0);
        chk("start_abort_idle_aborted", int'(aborted_o), 0);

        // err1 on addr 5 (cycle 8), err2 on addr 7 and 9 (cycles 11, 13).
        run_batch(32'h0000_0100, 32'h0000_2800, -1, 1, 2, 1, 5);
        // Same-cycle tie at cycle 10 -> slot2 addr 6; errors on empty slots ignored.
        run_batch(32'h0000_0404, 32'h0010_0408, -1, 1, 1, 1, 6);
        // Abort at cycle 8, then a clean batch clears aborted_o.
        run_batch(32'h0, 32'h0, 8, 0, 0, 0, 0);
        run_batch(32'h0, 32'h0, -1, 0, 0, 0, 0);

        // Async reset mid-batch at cycle 10.
        @(posedge clk); #1;
        start_i = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 9; i++) exp_rd.push_back('{t0 + 1 + i, i});
        for (int i = 0; i < 6; i++) exp_wr.push_back('{t0 + 4 + i, i});
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            err1_i = (k == 8);
        end
        err1_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_rd_en", int'(rd_en_o), 0);
        chk("arst_wr_en", int'(wr_en_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_stage_en", int'(stage_en_o), 0);
        chk("arst_err1", int'(err1_cnt_o), 0);
        chk("arst_fev", int'(first_err_vld_o), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_batch(32'h0000_0100, 32'h0, -1, 1, 0, 1, 5);

        // Saturation: err1 held through a 512-item batch.
        @(posedge clk); #1; start2 = 1'b1; err1_2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        for (int i = 0; i < 700 && !done2; i++) @(negedge clk);
        if (!done2) unexpected("sat_done_timeout");
        else begin
            chk("sat_err1", int'(e1cnt2), 255);
            chk("sat_err2", int'(e2cnt2), 0);
            chk("sat_fev", int'(fev2), 1);
            chk("sat_fea", int'(fea2), 0);
        end
        err1_2 = 1'b0;

        repeat (4) @(posedge clk);
        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("done_queue_drained", exp_dn.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
